// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and payload packing constants.
// Used by pipe_skid_reg and by the stages that pack payload words.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_DATA_W = 8;

    // Field offsets for stages that pack control and data into one payload word.
    localparam int unsigned PIPE_RS1_LSB       = 0;
    localparam int unsigned PIPE_RS1_W         = 5;
    localparam int unsigned PIPE_RS2_LSB       = PIPE_RS1_LSB + PIPE_RS1_W;
    localparam int unsigned PIPE_RS2_W         = 5;
    localparam int unsigned PIPE_REGWRITE_BIT  = PIPE_RS2_LSB + PIPE_RS2_W;
    localparam int unsigned PIPE_ALUOP_LSB     = PIPE_REGWRITE_BIT + 1;
    localparam int unsigned PIPE_ALUOP_W       = 3;
    localparam int unsigned PIPE_RESULT_LSB    = PIPE_ALUOP_LSB + PIPE_ALUOP_W;

    function automatic logic [1:0] occupancy_of(pipe_state_e st);
        unique case (st)
            StEmpty: occupancy_of = 2'd0;
            StBusy:  occupancy_of = 2'd1;
            StFull:  occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and two-entry skid buffer.
// Define PIPE_SKID_FLUSH_EN to add the synchronous flush input.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W     = PIPE_DATA_W,
    parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic              flush,
`endif
    output logic [1:0]        occupancy
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [1:0]        occupancy_q;
    logic              push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    main_d  = in_data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (push && pop) begin
                    main_d = in_data;
                end else if (push) begin
                    skid_d  = in_data;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: state_d = StEmpty;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Squash discards any push; payload registers are left untouched.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
    end

    // Handshake outputs are registered alongside the state so none of them has an input path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != StFull);
            out_valid_q <= (state_d != StEmpty);
            occupancy_q <= occupancy_of(state_d);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occupancy_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (8-bit payload).
module tb_pipe_skid_reg;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] occupancy;
`ifdef PIPE_SKID_FLUSH_EN
    logic       flush;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_skid_reg #(
        .DATA_W     (8),
        .RESET_DATA (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic ov, input logic ir,
                                input logic [1:0] occ, input logic [7:0] od);
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
        check({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, ir});
        check({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, occ});
        check({tag, ".out_data"},  {24'b0, out_data},  {24'b0, od});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        flush     = 1'b0;
`endif
        #1 reset = 1'b0;
        #1;
        check_status("reset_async", 1'b0, 1'b1, 2'd0, 8'h00);
        step();
        step();
        reset = 1'b1;
        check_status("reset_release", 1'b0, 1'b1, 2'd0, 8'h00);
        step();
        check_status("idle", 1'b0, 1'b1, 2'd0, 8'h00);

        // Streaming with out_ready high
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h11;
        step();
        check_status("stream_11", 1'b1, 1'b1, 2'd1, 8'h11);
        in_data = 8'h22;
        step();
        check_status("stream_22", 1'b1, 1'b1, 2'd1, 8'h22);
        in_data = 8'h33;
        step();
        check_status("stream_33", 1'b1, 1'b1, 2'd1, 8'h33);
        in_valid = 1'b0;
        step();
        check_status("stream_drain", 1'b0, 1'b1, 2'd0, 8'h33);

        // Fill to FULL under back-pressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
        step();
        check_status("fill_a1", 1'b1, 1'b1, 2'd1, 8'hA1);
        in_data = 8'hA2;
        step();
        check_status("fill_a2", 1'b1, 1'b0, 2'd2, 8'hA1);

        // Input ignored while FULL
        in_data = 8'hFF;
        step();
        check_status("full_hold0", 1'b1, 1'b0, 2'd2, 8'hA1);
        step();
        check_status("full_hold1", 1'b1, 1'b0, 2'd2, 8'hA1);
        step();
        check_status("full_hold2", 1'b1, 1'b0, 2'd2, 8'hA1);

        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_status("pop_a1", 1'b1, 1'b1, 2'd1, 8'hA2);
        step();
        check_status("pop_a2", 1'b0, 1'b1, 2'd0, 8'hA2);

        // Pop from FULL with in_valid high: input must not be taken that cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB1;
        step();
        in_data = 8'hB2;
        step();
        check_status("full_b", 1'b1, 1'b0, 2'd2, 8'hB1);
        out_ready = 1'b1; in_data = 8'hB3;
        step();
        check_status("pop_full_b1", 1'b1, 1'b1, 2'd1, 8'hB2);
        step();
        check_status("push_pop_b3", 1'b1, 1'b1, 2'd1, 8'hB3);
        in_valid = 1'b0;
        step();
        check_status("drain_b", 1'b0, 1'b1, 2'd0, 8'hB3);

        // Asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
        step();
        in_data = 8'h32;
        step();
        check_status("full_pre_reset", 1'b1, 1'b0, 2'd2, 8'h31);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_status("reset_mid", 1'b0, 1'b1, 2'd0, 8'h00);
        step();
        reset = 1'b1;
        in_valid = 1'b1; in_data = 8'h5C; out_ready = 1'b1;
        step();
        check_status("post_reset_5c", 1'b1, 1'b1, 2'd1, 8'h5C);
        in_valid = 1'b0;
        step();
        check_status("post_reset_drain", 1'b0, 1'b1, 2'd0, 8'h5C);

`ifdef PIPE_SKID_FLUSH_EN
        // Flush from FULL with a simultaneous push
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
        step();
        in_data = 8'hC2;
        step();
        check_status("full_pre_flush", 1'b1, 1'b0, 2'd2, 8'hC1);
        flush = 1'b1; in_data = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_status("flush", 1'b0, 1'b1, 2'd0, 8'hC1);
        out_ready = 1'b1;
        step();
        check_status("post_flush", 1'b0, 1'b1, 2'd0, 8'hC1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
